if_fetch: RTL and testbench

//   Instruction-fetch stage. Sits directly upstream of the decode stage, behind the IF/ID pipeline register.
//   - Owns the fetch PC and drives a req/ack instruction-memory port.
//   - Buffers returned words in a small FIFO.
//   - Presents {pc, inst, valid} to decode.
//   - Supports decode stall and branch/exception redirect (flush).

---
 rtl/if_fetch.sv | 167 ++++++++++++++++
 tb/tb_if_fetch.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the fetch PC, runs a single-outstanding
// req/ack instruction-memory port, buffers returned words in a small FIFO
// and presents {pc, inst, valid} to decode. Supports decode stall and
// branch/exception redirect (flush).
module if_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] new_pc_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t             state_reg;
    logic [31:0]        fetch_pc_reg;
    logic [31:0]        req_addr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   count_next;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [31:0]        fifo_pc_mem   [FIFO_DEPTH];
    logic [31:0]        fifo_inst_mem [FIFO_DEPTH];

    logic               push;
    logic               pop;
    logic               has_room;
    logic [31:0]        new_pc_aligned;
    logic [31:0]        fetch_pc_inc;

    // Redirect targets are always word aligned; low two bits are dropped.
    assign new_pc_aligned = new_pc_i & 32'hFFFF_FFFC;
    assign fetch_pc_inc   = fetch_pc_reg + 32'd4;

    // Memory port is a pure decode of the FSM state and the held address.
    assign imem_req_o  = (state_reg != IDLE);
    assign imem_addr_o = req_addr_reg;

    // Only a completed, non-flushed REQ transfer carries a useful word.
    assign push = (state_reg == REQ) && imem_ack_i && !flush_i;
    assign pop  = inst_valid_o && !stall_i && !flush_i;

    assign inst_valid_o = (count_reg != '0);

    // Occupancy after this edge; flush wins over push and pop.
    always_comb begin
        count_next = count_reg;
        if (flush_i) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count_reg + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    assign has_room = (count_next < DEPTH_C);

    // Fetch FSM: issue requests while there is room, discard stale data after a redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            fetch_pc_reg <= RESET_PC;
            req_addr_reg <= RESET_PC;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (flush_i) begin
                        fetch_pc_reg <= new_pc_aligned;
                        req_addr_reg <= new_pc_aligned;
                        state_reg    <= REQ;
                    end else if (has_room) begin
                        req_addr_reg <= fetch_pc_reg;
                        state_reg    <= REQ;
                    end
                end
                REQ: begin
                    if (flush_i) begin
                        fetch_pc_reg <= new_pc_aligned;
                        if (imem_ack_i) begin
                            // Returned word is stale; restart straight at the target.
                            req_addr_reg <= new_pc_aligned;
                            state_reg    <= REQ;
                        end else begin
                            // Request must stay up until memory acks it.
                            state_reg    <= DROP;
                        end
                    end else if (imem_ack_i) begin
                        fetch_pc_reg <= fetch_pc_inc;
                        if (has_room) begin
                            req_addr_reg <= fetch_pc_inc;
                            state_reg    <= REQ;
                        end else begin
                            state_reg    <= IDLE;
                        end
                    end
                end
                DROP: begin
                    if (flush_i) begin
                        fetch_pc_reg <= new_pc_aligned;
                    end
                    if (imem_ack_i) begin
                        req_addr_reg <= flush_i ? new_pc_aligned : fetch_pc_reg;
                        state_reg    <= REQ;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; reset and flush both empty the buffer.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
        end
    end

    // FIFO storage; contents are only observed through the valid-gated head.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_mem[wr_ptr_reg]   <= req_addr_reg;
            fifo_inst_mem[wr_ptr_reg] <= imem_rdata_i;
        end
    end

    // Head of FIFO to decode; an empty FIFO presents pc 0 and a NOP.
    always_comb begin
        pc_o   = 32'h0;
        inst_o = 32'h0;
        if (inst_valid_o) begin
            pc_o   = fifo_pc_mem[rd_ptr_reg];
            inst_o = fifo_inst_mem[rd_ptr_reg];
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: behavioural memory with programmable wait states,
// a scoreboard of expected fetch PCs refilled as decode consumes, and
// directed phases for stall, wait states, redirects, reset and PC wrap.
module tb_if_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
    logic        inst_valid;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_consumed = 0;
    int          wait_cnt = 0;
    int          mem_wait = 0;
    logic        hold_vld = 1'b0;
    logic [31:0] hold_addr = 32'h0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_next;
    logic [31:0] mon_pc;

    if_fetch #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req_o   (imem_req),
        .imem_addr_o  (imem_addr),
        .imem_ack_i   (imem_ack),
        .imem_rdata_i (imem_rdata),
        .stall_i      (stall),
        .flush_i      (flush),
        .new_pc_i     (new_pc),
        .pc_o         (pc_out),
        .inst_o       (inst_out),
        .inst_valid_o (inst_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Memory: ack after mem_wait wait states; data is junk outside the ack cycle.
    assign imem_ack   = imem_req && (wait_cnt >= mem_wait);
    assign imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hBAD0_0000;

    always @(posedge clk) begin
        if (rst || !imem_req || imem_ack) wait_cnt <= 0;
        else                              wait_cnt <= wait_cnt + 1;
        hold_vld  <= !rst && imem_req && !imem_ack;
        hold_addr <= imem_addr;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Restart the expected stream at a new (aligned) PC.
    task automatic reset_sb(input logic [31:0] start);
        exp_q.delete();
        exp_next = start & 32'hFFFF_FFFC;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(exp_next);
            exp_next = exp_next + 32'd4;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Decode-side monitor: every consumed instruction is checked against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (hold_vld && imem_req) check_eq("addr_hold", imem_addr, hold_addr);
            if (imem_req) check_eq("addr_align", {30'h0, imem_addr[1:0]}, 32'h0);
            if (!inst_valid) begin
                check_eq("empty_pc", pc_out, 32'h0);
                check_eq("empty_inst", inst_out, 32'h0);
            end else if (!stall && !flush) begin
                mon_pc = exp_q.pop_front();
                exp_q.push_back(exp_next);
                exp_next = exp_next + 32'd4;
                $display("fetch pc=%08h inst=%08h (expect pc=%08h)", pc_out, inst_out, mon_pc);
                check_eq("pc", pc_out, mon_pc);
                check_eq("inst", inst_out, mem_word(mon_pc));
                n_consumed++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

    initial begin
        int   c0;
        logic found;
        logic [31:0] held_pc;
        logic [31:0] stale;

        rst = 1'b1; stall = 1'b0; flush = 1'b0; new_pc = 32'h0; mem_wait = 0;
        reset_sb(RESET_PC);

        // Reset values
        step(); step();
        check_eq("rst_req", imem_req, 1'b0);
        check_eq("rst_addr", imem_addr, RESET_PC);
        check_eq("rst_valid", inst_valid, 1'b0);
        check_eq("rst_pc", pc_out, 32'h0);
        check_eq("rst_inst", inst_out, 32'h0);

        // Phase 1: zero-wait memory, first req in cycle 1, first valid in cycle 2
        rst = 1'b0;
        reset_sb(RESET_PC);
        check_eq("c0_req", imem_req, 1'b0);
        step();
        check_eq("c1_req", imem_req, 1'b1);
        check_eq("c1_addr", imem_addr, RESET_PC);
        check_eq("c1_valid", inst_valid, 1'b0);
        step();
        check_eq("c2_valid", inst_valid, 1'b1);
        check_eq("c2_pc", pc_out, RESET_PC);
        c0 = n_consumed;
        repeat (10) step();
        check_eq("steady_rate", n_consumed - c0, 10);

        // Phase 2: stall fills the FIFO, request drops, head held
        held_pc = exp_q[0];
        stall = 1'b1;
        repeat (5) step();
        check_eq("stall_req", imem_req, 1'b0);
        check_eq("stall_valid", inst_valid, 1'b1);
        check_eq("stall_pc", pc_out, held_pc);
        stall = 1'b0;
        c0 = n_consumed;
        repeat (6) step();
        check_eq("release_rate", n_consumed - c0, 6);

        // Phase 3: three wait states, one instruction every four cycles
        mem_wait = 3;
        repeat (12) step();
        c0 = n_consumed;
        repeat (40) step();
        check_eq("wait_rate", n_consumed - c0, 10);

        // Phase 4: flush during a waited request -> stale word dropped
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req && !imem_ack) begin found = 1'b1; break; end
            step();
        end
        check_eq("t4_find", found, 1'b1);
        stale = imem_addr;
        flush = 1'b1; new_pc = 32'h0000_0100;
        step();
        flush = 1'b0; new_pc = 32'h0;
        reset_sb(32'h0000_0100);
        check_eq("drop_req", imem_req, 1'b1);
        check_eq("drop_addr", imem_addr, stale);
        check_eq("drop_valid", inst_valid, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_ack) begin found = 1'b1; break; end
            step();
        end
        check_eq("t4_ack", found, 1'b1);
        step();
        check_eq("redirect_addr", imem_addr, 32'h0000_0100);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (inst_valid) begin found = 1'b1; break; end
        end
        check_eq("t4_valid", found, 1'b1);
        check_eq("t4_pc", pc_out, 32'h0000_0100);

        // Phase 5: flush coincident with ack, unaligned target
        mem_wait = 0;
        repeat (4) step();
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req && imem_ack) begin found = 1'b1; break; end
            step();
        end
        check_eq("t5_find", found, 1'b1);
        flush = 1'b1; new_pc = 32'h0000_0203;
        step();
        flush = 1'b0; new_pc = 32'h0;
        reset_sb(32'h0000_0200);
        check_eq("t5_valid", inst_valid, 1'b0);
        check_eq("t5_req", imem_req, 1'b1);
        check_eq("t5_addr", imem_addr, 32'h0000_0200);
        c0 = n_consumed;
        repeat (6) step();
        check_eq("t5_rate", n_consumed - c0, 5);

        // Phase 5b: flush while idle with a full FIFO
        stall = 1'b1;
        repeat (4) step();
        check_eq("idle_req", imem_req, 1'b0);
        flush = 1'b1; new_pc = 32'h0000_0300;
        step();
        flush = 1'b0; new_pc = 32'h0; stall = 1'b0;
        reset_sb(32'h0000_0300);
        check_eq("idle_flush_valid", inst_valid, 1'b0);
        c0 = n_consumed;
        repeat (6) step();
        check_eq("idle_flush_flow", (n_consumed - c0) >= 4, 1'b1);

        // Phase 6: reset in the middle of a request at 0x40
        mem_wait = 3;
        flush = 1'b1; new_pc = 32'h0000_0040;
        step();
        flush = 1'b0; new_pc = 32'h0;
        reset_sb(32'h0000_0040);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req && !imem_ack && imem_addr == 32'h0000_0040) begin found = 1'b1; break; end
            step();
        end
        check_eq("t6_find", found, 1'b1);
        rst = 1'b1;
        step();
        check_eq("t6_req", imem_req, 1'b0);
        check_eq("t6_valid", inst_valid, 1'b0);
        check_eq("t6_addr", imem_addr, RESET_PC);
        check_eq("t6_pc", pc_out, 32'h0);
        mem_wait = 0;
        rst = 1'b0;
        reset_sb(RESET_PC);
        step();
        check_eq("t6_restart_req", imem_req, 1'b1);
        check_eq("t6_restart_addr", imem_addr, RESET_PC);
        c0 = n_consumed;
        repeat (8) step();
        check_eq("t6_rate", n_consumed - c0, 7);

        // Phase 7: PC wrap from 0xFFFFFFFC to 0
        flush = 1'b1; new_pc = 32'hFFFF_FFFC;
        step();
        flush = 1'b0; new_pc = 32'h0;
        reset_sb(32'hFFFF_FFFC);
        c0 = n_consumed;
        repeat (8) step();
        check_eq("wrap_flow", (n_consumed - c0) >= 3, 1'b1);

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
